vc_random_stream_gen: RTL
=========================

# vc_random_stream_gen

Multi-channel pseudo-random number source with a latency-insensitive val/rdy output per channel. It supports runtime reseeding and optional bias-free range limiting. It is the stimulus engine for test sources/sinks and random-delay injectors in cache and network test harnesses, and replaces ad-hoc per-bench single-channel generators. Each channel runs an independent 32-bit xorshift state, XOR-folded down to the output width and buffered in a one-entry output register.

## Interface
- p_nchannels, 1: number of independent channels (1..8)
- p_out_nbits, 4: output width per channel (1..32)
- p_seed, 32'h1: base 32-bit seed applied at reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- seed_val  in  1  reseed request
- seed_rdy  out  1  reseed accepted; constant 1
- seed_msg  in  32  new base seed
- max_val  in  p_out_nbits  inclusive upper bound on outputs (range mode only)
- out_val  out  p_nchannels  per-channel output valid
- out_rdy  in  p_nchannels  per-channel consumer ready
- out_msg  out  p_nchannels*p_out_nbits  channel c at bits [c*p_out_nbits +: p_out_nbits]

## Operation
- Channel seed: s_c = base ^ (c * 32'h9E3779B9), mod 2^32. If s_c == 0, substitute 32'h1 (an all-zero state is absorbing).
- Step function: x ^= x<<13; x ^= x>>17; x ^= x<<5 (all 32-bit, truncating).
- Fold: XOR of consecutive p_out_nbits slices of the state, starting at bit 0. The top slice is zero-padded.
- Candidate each cycle: cand_c = fold(state_c).
- Per-channel FSM, states EMPTY and FULL:
  - EMPTY: each cycle, state_c <= step(state_c). If cand_c is accepted, load buffer and go to FULL; otherwise stay EMPTY.
  - FULL: hold buffer and state. On out_val&&out_rdy, the buffer is freed in the same cycle. If cand_c is accepted, reload and step (stay FULL); otherwise step and go to EMPTY.
- Acceptance: always accepted unless range mode is compiled in (see Configuration).
- Reseed: seed_val&&seed_rdy sets all state_c <= s_c(seed_msg) and all buffers to EMPTY.
  - Any out transfer in the same cycle completes normally; its data is then dropped.
  - Reseed overrides candidate loading in that cycle.
- Channels are fully independent. One channel's stall never stalls another.
- Reset values: out_val = 0, out_msg = 0, state_c = s_c(p_seed), FSM = EMPTY, seed_rdy = 1.

## Timing
- First out_val rises on the first cycle after reset deasserts. Its value is fold(s_c).
- Throughput is one value per cycle per channel under continuous out_rdy (no range rejects).
- Each rejected candidate costs exactly one bubble cycle.
- After a reseed, out_val is low for the next cycle. The new sequence appears the cycle after that.
- out_msg is stable while out_val&&!out_rdy.
- max_val is sampled only at candidate evaluation. A buffered value is never re-checked against a later max_val.
- Reset asserted mid-stream clears everything on that edge, regardless of val/rdy or seed_val.

## Configuration
- VC_RANDOM_STREAM_GEN_RANGE_EN defined:
  - mask = smallest 2^k-1 >= max_val.
  - cand_c = fold & mask.
  - Accept iff cand_c <= max_val.
  - max_val = 0 always yields 0 with no rejects.
- Undefined: max_val is ignored, every candidate is accepted, and output is full-range. The port remains present so benches link unchanged.

## Structure
- Shared package/defs include holds:
  - the golden-ratio seed constant 32'h9E3779B9 and the zero-seed substitute 32'h1;
  - the FSM state encodings (EMPTY = 0, FULL = 1);
  - the fold and step functions, so bench models reuse them.
- One natural sub-module, vc_RandomStreamGenChannel, instantiated p_nchannels times by generate. It contains the state register (codebase enable/reset register), output buffer, FSM and range check.
- Top level holds seed derivation and port packing only.

## Test plan
- Reset release, p_nchannels=1, p_out_nbits=4, p_seed=1, out_rdy=1 -> out_msg sequence 0x1, 0x5, 0xB. out_val high every cycle from cycle 1.
- Same setup, range mode, max_val=4 -> outputs 0x1, then one cycle out_val=0 (candidate 5 rejected), then 0x3.
- out_rdy=0 for 10 cycles after the first valid -> out_msg held at 0x1. After release, next value is 0x5 (no values skipped).
- p_nchannels=2, stall channel 1 only -> channel 0 sequence is unaffected; channel 1 resumes from its held value.
- seed_val=1, seed_msg=1, issued mid-stream together with an out transfer -> transfer counted, out_val=0 next cycle, then 0x1, 0x5 again. seed_msg=0 behaves as seed 1 for channel 0.
- Reset asserted while FULL and stalled -> out_val=0 next cycle, then sequence restarts at 0x1.

Source files
------------

// File: rtl/vc_random_stream_gen_pkg.sv
// Shared definitions for vc_random_stream_gen: seed constants, channel FSM
// states, and the xorshift step / XOR-fold / channel-seed helper functions.
package vc_random_stream_gen_pkg;

    localparam logic [31:0] GOLDEN_SEED   = 32'h9E3779B9;
    localparam logic [31:0] ZERO_SEED_SUB = 32'h1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_e;

    // One xorshift32 step (13, 17, 5).
    function automatic logic [31:0] xs_step(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    // XOR of consecutive nbits-wide slices starting at bit 0; the top slice
    // is implicitly zero-padded. Only the low nbits of the result are used.
    function automatic logic [31:0] xs_fold(input logic [31:0] x,
                                            input int unsigned nbits);
        logic [31:0] r;
        r = '0;
        for (int unsigned j = 0; j < 32; j++) begin
            r[5'(j % nbits)] = r[5'(j % nbits)] ^ x[5'(j)];
        end
        return r;
    endfunction

    // Per-channel seed; an all-zero state would never leave zero.
    function automatic logic [31:0] chan_seed(input logic [31:0] base,
                                              input int unsigned c);
        logic [31:0] s;
        s = base ^ (32'(c) * GOLDEN_SEED);
        return (s == '0) ? ZERO_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/vc_random_stream_gen_channel.sv
// One channel of vc_random_stream_gen: xorshift state register, one-entry
// output buffer with EMPTY/FULL FSM, and the optional range check enabled by
// VC_RANDOM_STREAM_GEN_RANGE_EN.
module vc_RandomStreamGenChannel
    import vc_random_stream_gen_pkg::*;
#(
    parameter int unsigned p_out_nbits   = 4,
    parameter logic [31:0] p_reset_state = 32'h1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   reseed_i,
    input  logic [31:0]            reseed_state_i,
    input  logic [p_out_nbits-1:0] max_val_i,
    output logic                   out_val_o,
    input  logic                   out_rdy_i,
    output logic [p_out_nbits-1:0] out_msg_o
);

    logic [31:0]            state_q;
    logic [31:0]            state_d;
    logic [p_out_nbits-1:0] msg_q;
    chan_state_e            fsm_q;
    logic [p_out_nbits-1:0] fold_w;
    logic [p_out_nbits-1:0] cand;
    logic                   accept;

    assign state_d = xs_step(state_q);
    assign fold_w  = p_out_nbits'(xs_fold(state_q, p_out_nbits));

`ifdef VC_RANDOM_STREAM_GEN_RANGE_EN
    logic [p_out_nbits-1:0] mask;

    // Smallest 2^k-1 covering max_val, then reject candidates above max_val.
    always_comb begin
        mask = '0;
        for (int unsigned i = 0; i < p_out_nbits; i++) begin
            mask[i] = |(max_val_i >> i);
        end
        cand   = fold_w & mask;
        accept = (cand <= max_val_i);
    end
`else
    logic unused_max_val;
    assign unused_max_val = ^max_val_i;

    // Full-range output: every candidate is accepted.
    always_comb begin
        cand   = fold_w;
        accept = 1'b1;
    end
`endif

    // Channel FSM: state steps whenever the buffer is or becomes free.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= p_reset_state;
            fsm_q   <= ST_EMPTY;
            msg_q   <= '0;
        end else if (reseed_i) begin
            // A concurrent out transfer still completes; its slot is dropped.
            state_q <= reseed_state_i;
            fsm_q   <= ST_EMPTY;
        end else begin
            case (fsm_q)
                ST_EMPTY: begin
                    state_q <= state_d;
                    if (accept) begin
                        msg_q <= cand;
                        fsm_q <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_rdy_i) begin
                        state_q <= state_d;
                        if (accept) begin
                            msg_q <= cand;
                        end else begin
                            fsm_q <= ST_EMPTY;
                        end
                    end
                end
            endcase
        end
    end

    assign out_val_o = (fsm_q == ST_FULL);
    assign out_msg_o = msg_q;

endmodule

// File: rtl/vc_random_stream_gen.sv
// Multi-channel xorshift random stream source with per-channel val/rdy.
// Range limiting is compiled in with VC_RANDOM_STREAM_GEN_RANGE_EN.
// Top level: per-channel seed derivation and port packing only.
module vc_random_stream_gen
    import vc_random_stream_gen_pkg::*;
#(
    parameter int unsigned p_nchannels = 1,
    parameter int unsigned p_out_nbits = 4,
    parameter logic [31:0] p_seed      = 32'h1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               seed_val,
    output logic                               seed_rdy,
    input  logic [31:0]                        seed_msg,
    input  logic [p_out_nbits-1:0]             max_val,
    output logic [p_nchannels-1:0]             out_val,
    input  logic [p_nchannels-1:0]             out_rdy,
    output logic [p_nchannels*p_out_nbits-1:0] out_msg
);

    logic reseed;

    assign seed_rdy = 1'b1;
    assign reseed   = seed_val & seed_rdy;

    for (genvar c = 0; c < p_nchannels; c++) begin : g_chan
        logic [31:0] reseed_state;
        assign reseed_state = chan_seed(seed_msg, c);

        vc_RandomStreamGenChannel #(
            .p_out_nbits  (p_out_nbits),
            .p_reset_state(chan_seed(p_seed, c))
        ) u_chan (
            .clk_i         (clk),
            .reset_i       (reset),
            .reseed_i      (reseed),
            .reseed_state_i(reseed_state),
            .max_val_i     (max_val),
            .out_val_o     (out_val[c]),
            .out_rdy_i     (out_rdy[c]),
            .out_msg_o     (out_msg[c*p_out_nbits +: p_out_nbits])
        );
    end

endmodule
